// File: rtl/wb_ram512x64_bridge_pkg.sv
// Shared types and widths for the Wishbone-to-RAM_512x64 bridge.
package wb_ram512x64_bridge_pkg;

  localparam int RAM_AW = 9;
  localparam int RAM_DW = 64;
  localparam int RAM_NB = 8;
  localparam int WB_DW  = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ACK     = 2'd2
  } state_e;

  // Place the four Wishbone byte selects on the addressed half of the 64-bit word.
  function automatic logic [RAM_NB-1:0] steer_we(input logic half, input logic [3:0] sel);
    if (half) begin
      steer_we = {sel, 4'b0000};
    end else begin
      steer_we = {4'b0000, sel};
    end
  endfunction

endpackage

// File: rtl/wb_ram512x64_bridge.sv
// Wishbone-classic slave mapping a 4 KiB window onto one 512x64 synchronous RAM;
// 32-bit accesses are steered onto the addressed half of each 64-bit word.
module wb_ram512x64_bridge
  import wb_ram512x64_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [WB_DW-1:0]  wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [WB_DW-1:0]  wbs_dat_o,
  output logic              ram_en_o,
  output logic [RAM_NB-1:0] ram_we_o,
  output logic [RAM_AW-1:0] ram_a_o,
  output logic [RAM_DW-1:0] ram_di_o,
  input  logic [RAM_DW-1:0] ram_do_i
);

  state_e             state_q, state_d;
  logic               ack_q, ack_d;
  logic [WB_DW-1:0]   dat_q, dat_d;
  logic               half_q, half_d;
  logic               req_s;
  logic               en_s;
  logic               wr_s;
  logic [RAM_NB-1:0]  we_s;

  // The !ack term stops a master that still holds stb during its ack cycle from re-issuing.
  assign req_s = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR) & ~ack_q;

  // State register and registered Wishbone outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= {WB_DW{1'b0}};
      half_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      half_q  <= half_d;
    end
  end

  // Next-state logic and combinational RAM strobes.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    half_d  = half_q;
    en_s    = 1'b0;
    wr_s    = 1'b0;
    we_s    = {RAM_NB{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          if (wbs_we_i) begin
            // An empty byte mask is still acknowledged but leaves the RAM untouched.
            en_s    = |wbs_sel_i;
            wr_s    = |wbs_sel_i;
            we_s    = steer_we(wbs_adr_i[2], wbs_sel_i);
            ack_d   = 1'b1;
            state_d = ST_ACK;
          end else begin
            en_s    = 1'b1;
            half_d  = wbs_adr_i[2];
            state_d = ST_RD_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (wbs_cyc_i) begin
          dat_d   = half_q ? ram_do_i[63:32] : ram_do_i[31:0];
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM strobes are gated by RST_N so a write still pending when reset arrives never lands.
  assign ram_en_o  = en_s & RST_N;
  assign ram_we_o  = RST_N ? we_s : {RAM_NB{1'b0}};
  assign ram_a_o   = ram_en_o ? wbs_adr_i[11:3] : {RAM_AW{1'b0}};
  assign ram_di_o  = (wr_s & RST_N) ? {wbs_dat_i, wbs_dat_i} : {RAM_DW{1'b0}};
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_ram512x64_bridge.sv
// Randomized self-checking bench: transaction-level memory model plus per-cycle output checks.
module tb_wb_ram512x64_bridge;

  logic        CLK;
  logic        RST_N;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        ram_en_o;
  logic [7:0]  ram_we_o;
  logic [8:0]  ram_a_o;
  logic [63:0] ram_di_o;
  logic [63:0] ram_do;

  int checks;
  int failures;

  logic [63:0] ram_mem [0:511] = '{default: 64'h0};
  logic [63:0] ref_mem [0:511] = '{default: 64'h0};

  logic        exp_ack, exp_en;
  logic [31:0] exp_dat;
  logic [7:0]  exp_we;
  logic [8:0]  exp_a;
  logic [63:0] exp_di;
  logic [7:0]  seen_we;
  logic [8:0]  seen_a;

  wb_ram512x64_bridge dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .ram_en_o  (ram_en_o),
    .ram_we_o  (ram_we_o),
    .ram_a_o   (ram_a_o),
    .ram_di_o  (ram_di_o),
    .ram_do_i  (ram_do)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural RAM_512x64 macro.
  always @(posedge CLK) begin
    if (ram_en_o) begin
      for (int b = 0; b < 8; b++) begin
        if (ram_we_o[b]) ram_mem[ram_a_o][b*8 +: 8] <= ram_di_o[b*8 +: 8];
      end
      if (ram_we_o == 8'h00) ram_do <= ram_mem[ram_a_o];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_exp();
    exp_en  = 1'b0;
    exp_we  = 8'h00;
    exp_a   = 9'd0;
    exp_di  = 64'h0;
    exp_ack = 1'b0;
  endtask

  task automatic drop_bus();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
  endtask

  // mode: 0 = normal, 1 = abort read in wait cycle, 2 = reset pulse in wait cycle.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input int mode);
    logic       hit;
    logic [8:0] w;
    logic       h;
    hit = (adr[31:12] == 20'h30000);
    w   = adr[11:3];
    h   = adr[2];
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_sel_i = sel;
    wbs_dat_i = dat;
    if (!hit) begin
      idle_exp();
      repeat (10) step();
      drop_bus();
    end else if (we) begin
      exp_en  = (sel != 4'h0);
      exp_we  = h ? {sel, 4'h0} : {4'h0, sel};
      exp_a   = exp_en ? w : 9'd0;
      exp_di  = exp_en ? {dat, dat} : 64'h0;
      exp_ack = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) ref_mem[w][(h ? 32 : 0) + i*8 +: 8] = dat[i*8 +: 8];
      end
      idle_exp();
      exp_ack = 1'b1;
      step();
      drop_bus();
      idle_exp();
    end else begin
      exp_en  = 1'b1;
      exp_we  = 8'h00;
      exp_a   = w;
      exp_di  = 64'h0;
      exp_ack = 1'b0;
      step();
      idle_exp();
      if (mode == 1) drop_bus();
      if (mode == 2) begin
        RST_N   = 1'b0;
        drop_bus();
        exp_dat = 32'h0;
      end
      step();
      if (mode == 0) begin
        exp_ack = 1'b1;
        exp_dat = h ? ref_mem[w][63:32] : ref_mem[w][31:0];
      end
      if (mode == 2) RST_N = 1'b1;
      step();
      drop_bus();
      idle_exp();
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    RST_N     = 1'b0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b1;
    wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3000_0000;
    wbs_dat_i = 32'h5555_AAAA;
    exp_dat   = 32'h0;
    seen_we   = 8'h00;
    seen_a    = 9'd0;
    idle_exp();

    fork
      forever begin
        @(negedge CLK);
        check("ack", {63'd0, wbs_ack_o}, {63'd0, exp_ack});
        check("dat_o", {32'd0, wbs_dat_o}, {32'd0, exp_dat});
        check("ram_en", {63'd0, ram_en_o}, {63'd0, exp_en});
        check("ram_we", {56'd0, ram_we_o}, {56'd0, exp_we});
        check("ram_a", {55'd0, ram_a_o}, {55'd0, exp_a});
        check("ram_di", ram_di_o, exp_di);
        if (ram_en_o) begin
          seen_we = ram_we_o;
          seen_a  = ram_a_o;
        end
      end
    join_none

    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    drop_bus();
    step();

    wb_xfer(1'b1, 32'h3000_0004, 4'hF, 32'hDEADBEEF, 0);
    check("t1_we_lit", {56'd0, seen_we}, 64'h0000_0000_0000_00F0);
    check("t1_a_lit", {55'd0, seen_a}, 64'd0);
    wb_xfer(1'b0, 32'h3000_0004, 4'hF, 32'h0, 0);
    check("t1_rd_lit", {32'd0, wbs_dat_o}, 64'h0000_0000_DEAD_BEEF);

    wb_xfer(1'b1, 32'h3000_0FF8, 4'hF, 32'hAABBCCDD, 0);
    wb_xfer(1'b1, 32'h3000_0FF8, 4'b0101, 32'h11223344, 0);
    check("lane_a_lit", {55'd0, seen_a}, 64'd511);
    check("lane_we_lit", {56'd0, seen_we}, 64'h05);
    wb_xfer(1'b0, 32'h3000_0FF8, 4'hF, 32'h0, 0);
    check("lane_rd_lit", {32'd0, wbs_dat_o}, 64'h0000_0000_AA22_CC44);

    wb_xfer(1'b0, 32'h3000_1000, 4'hF, 32'h0, 0);
    check("oow_hold_lit", {32'd0, wbs_dat_o}, 64'h0000_0000_AA22_CC44);

    wb_xfer(1'b0, 32'h3000_0004, 4'hF, 32'h0, 1);
    check("abort_hold_lit", {32'd0, wbs_dat_o}, 64'h0000_0000_AA22_CC44);
    wb_xfer(1'b0, 32'h3000_0004, 4'hF, 32'h0, 0);
    check("abort_next_lit", {32'd0, wbs_dat_o}, 64'h0000_0000_DEAD_BEEF);

    wb_xfer(1'b0, 32'h3000_0004, 4'hF, 32'h0, 2);
    check("rst_dat_lit", {32'd0, wbs_dat_o}, 64'd0);
    wb_xfer(1'b1, 32'h3000_0104, 4'hF, 32'hCAFEF00D, 0);
    wb_xfer(1'b0, 32'h3000_0104, 4'hF, 32'h0, 0);
    check("rst_next_lit", {32'd0, wbs_dat_o}, 64'h0000_0000_CAFE_F00D);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] adr;
      logic        we;
      int          mode;
      we   = $urandom_range(0, 1) == 1;
      mode = 0;
      if (!we && $urandom_range(0, 7) == 0) mode = 1;
      if (!we && $urandom_range(0, 15) == 0) mode = 2;
      if ($urandom_range(0, 19) == 0) begin
        adr = $urandom;
      end else begin
        adr = 32'h3000_0000 + 32'($urandom_range(0, 15) * 8) + 32'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) adr = adr + 32'h0000_0F80;
      end
      wb_xfer(we, adr, 4'($urandom_range(0, 15)), $urandom, mode);
      if ($urandom_range(0, 3) == 0) step();
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
